// File: rtl/mc_alu_sequencer.sv
// Multicycle control FSM for a MIPS-I ALU/lw/sw subset: fetches over a req/ack port,
// decodes the latched IR and sequences IF->ID->EX->(MEM)->WB, driving the one-hot ALU bus.
module mc_alu_sequencer #(
    parameter int ALU_CTRL_W  = 12,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  inst_req,
    input  logic                  inst_ack,
    input  logic [31:0]           inst_rdata,
    output logic                  data_req,
    output logic                  data_wr,
    input  logic                  data_ack,
    output logic                  pc_we,
    output logic                  ir_we,
    output logic                  alu_out_we,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            alu_src1_sel,
    output logic [1:0]            alu_src2_sel,
    output logic                  rf_we,
    output logic                  rf_wdst_sel,
    output logic                  rf_wdata_sel,
    output logic                  illegal_inst,
    output logic                  bus_err,
    output logic [2:0]            state
);

    localparam logic [2:0] S_RST = 3'd0;
    localparam logic [2:0] S_IF  = 3'd1;
    localparam logic [2:0] S_ID  = 3'd2;
    localparam logic [2:0] S_EX  = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4;
    localparam logic [2:0] S_WB  = 3'd5;

    localparam logic [ALU_CTRL_W-1:0] OP_ADD  = ALU_CTRL_W'(12'h001);
    localparam logic [ALU_CTRL_W-1:0] OP_SUB  = ALU_CTRL_W'(12'h002);
    localparam logic [ALU_CTRL_W-1:0] OP_SLT  = ALU_CTRL_W'(12'h004);
    localparam logic [ALU_CTRL_W-1:0] OP_SLTU = ALU_CTRL_W'(12'h008);
    localparam logic [ALU_CTRL_W-1:0] OP_AND  = ALU_CTRL_W'(12'h010);
    localparam logic [ALU_CTRL_W-1:0] OP_NOR  = ALU_CTRL_W'(12'h020);
    localparam logic [ALU_CTRL_W-1:0] OP_OR   = ALU_CTRL_W'(12'h040);
    localparam logic [ALU_CTRL_W-1:0] OP_XOR  = ALU_CTRL_W'(12'h080);
    localparam logic [ALU_CTRL_W-1:0] OP_SLL  = ALU_CTRL_W'(12'h100);
    localparam logic [ALU_CTRL_W-1:0] OP_SRL  = ALU_CTRL_W'(12'h200);
    localparam logic [ALU_CTRL_W-1:0] OP_SRA  = ALU_CTRL_W'(12'h400);
    localparam logic [ALU_CTRL_W-1:0] OP_LUI  = ALU_CTRL_W'(12'h800);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             tmo_hit;
    logic             timeout;

    logic [5:0]            opcode, funct;
    logic                  dec_legal, dec_rtype, dec_mem, dec_sw;
    logic [ALU_CTRL_W-1:0] dec_op;
    logic [1:0]            dec_src1, dec_src2;

    // Register/immediate fields are consumed by the datapath, not by control.
    logic unused_ir;
    assign unused_ir = ^ir_q[25:6];

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    always_comb begin
        dec_legal = 1'b1;
        dec_rtype = 1'b0;
        dec_mem   = 1'b0;
        dec_sw    = 1'b0;
        dec_op    = '0;
        dec_src1  = 2'd0;
        dec_src2  = 2'd0;
        case (opcode)
            6'h00: begin
                dec_rtype = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h24: dec_op = OP_AND;
                    6'h25: dec_op = OP_OR;
                    6'h26: dec_op = OP_XOR;
                    6'h27: dec_op = OP_NOR;
                    6'h2A: dec_op = OP_SLT;
                    6'h2B: dec_op = OP_SLTU;
                    6'h00: begin dec_op = OP_SLL; dec_src1 = 2'd1; end
                    6'h02: begin dec_op = OP_SRL; dec_src1 = 2'd1; end
                    6'h03: begin dec_op = OP_SRA; dec_src1 = 2'd1; end
                    6'h04: dec_op = OP_SLL;
                    6'h06: dec_op = OP_SRL;
                    6'h07: dec_op = OP_SRA;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin dec_op = OP_ADD;  dec_src2 = 2'd1; end
            6'h0A:        begin dec_op = OP_SLT;  dec_src2 = 2'd1; end
            6'h0B:        begin dec_op = OP_SLTU; dec_src2 = 2'd1; end
            6'h0C:        begin dec_op = OP_AND;  dec_src2 = 2'd2; end
            6'h0D:        begin dec_op = OP_OR;   dec_src2 = 2'd2; end
            6'h0E:        begin dec_op = OP_XOR;  dec_src2 = 2'd2; end
            6'h0F:        begin dec_op = OP_LUI;  dec_src2 = 2'd2; end
            6'h23:        begin dec_op = OP_ADD;  dec_src2 = 2'd1; dec_mem = 1'b1; end
            6'h2B: begin
                dec_op   = OP_ADD;
                dec_src2 = 2'd1;
                dec_mem  = 1'b1;
                dec_sw   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // wait_q counts completed wait cycles, so the Nth cycle sees N-1; an ack that cycle still wins.
    assign tmo_hit = (ACK_TIMEOUT > 0) && (wait_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                if (inst_ack)     state_d = S_ID;
                else if (tmo_hit) timeout = 1'b1;
            end
            S_ID:  state_d = dec_legal ? S_EX : S_IF;
            S_EX:  state_d = dec_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (data_ack) state_d = dec_sw ? S_IF : S_WB;
                else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q || timeout)
            wait_d = '0;
        else if (ACK_TIMEOUT > 0 && (state_q == S_IF || state_q == S_MEM))
            wait_d = wait_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_IF && inst_ack)
                ir_q <= inst_rdata;
        end
    end

    always_comb begin
        inst_req     = 1'b0;
        data_req     = 1'b0;
        data_wr      = 1'b0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        alu_out_we   = 1'b0;
        alu_control  = '0;
        alu_src1_sel = 2'd0;
        alu_src2_sel = 2'd0;
        rf_we        = 1'b0;
        rf_wdst_sel  = 1'b0;
        rf_wdata_sel = 1'b0;
        illegal_inst = 1'b0;
        case (state_q)
            S_IF: begin
                inst_req     = 1'b1;
                alu_control  = OP_ADD;
                alu_src1_sel = 2'd2;
                alu_src2_sel = 2'd3;
                pc_we        = inst_ack;
                ir_we        = inst_ack;
            end
            S_ID: illegal_inst = ~dec_legal;
            S_EX: begin
                alu_control  = dec_op;
                alu_src1_sel = dec_src1;
                alu_src2_sel = dec_src2;
                alu_out_we   = 1'b1;
            end
            S_MEM: begin
                data_req = 1'b1;
                data_wr  = dec_sw;
            end
            S_WB: begin
                rf_we        = 1'b1;
                rf_wdst_sel  = ~dec_rtype;
                rf_wdata_sel = dec_mem;
            end
            default: ;
        endcase
    end

    assign bus_err = timeout;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Directed bench for mc_alu_sequencer with ACK_TIMEOUT=8; expected values are hand-derived.
module tb_mc_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_ack;
    logic        pc_we, ir_we, alu_out_we;
    logic [11:0] alu_control;
    logic [1:0]  alu_src1_sel, alu_src2_sel;
    logic        rf_we, rf_wdst_sel, rf_wdata_sel;
    logic        illegal_inst, bus_err;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    mc_alu_sequencer #(.ALU_CTRL_W(12), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_ack(data_ack),
        .pc_we(pc_we), .ir_we(ir_we), .alu_out_we(alu_out_we),
        .alu_control(alu_control), .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel),
        .rf_we(rf_we), .rf_wdst_sel(rf_wdst_sel), .rf_wdata_sel(rf_wdata_sel),
        .illegal_inst(illegal_inst), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b0, inst_req, data_req, data_wr, pc_we, ir_we, alu_out_we, alu_control,
                alu_src1_sel, alu_src2_sel, rf_we, rf_wdst_sel, rf_wdata_sel,
                illegal_inst, bus_err, state};
    endfunction

    // Entered in the first IF cycle; fetches with an immediate ack and walks IF,ID,EX,WB.
    task automatic run_alu(input string nm, input logic [31:0] inst, input logic [11:0] ctrl,
                           input logic [1:0] s1, input logic [1:0] s2, input logic wdst);
        inst_ack = 1'b1; inst_rdata = inst; #1;
        chk({nm, " IF state"}, 32'(state), 32'd1);
        chk({nm, " IF pc/ir we"}, {30'd0, pc_we, ir_we}, 32'h3);
        cyc(); inst_ack = 1'b0; #1;
        chk({nm, " ID state"}, 32'(state), 32'd2);
        chk({nm, " ID req/illegal"}, {30'd0, inst_req, illegal_inst}, 32'h0);
        cyc(); #1;
        chk({nm, " EX state"}, 32'(state), 32'd3);
        chk({nm, " EX alu_control"}, 32'(alu_control), 32'(ctrl));
        chk({nm, " EX src"}, {28'd0, alu_src1_sel, alu_src2_sel}, {28'd0, s1, s2});
        chk({nm, " EX alu_out_we"}, 32'(alu_out_we), 32'd1);
        cyc(); #1;
        chk({nm, " WB state"}, 32'(state), 32'd5);
        chk({nm, " WB rf"}, {29'd0, rf_we, rf_wdst_sel, rf_wdata_sel}, {29'd0, 1'b1, wdst, 1'b0});
        chk({nm, " WB alu_control"}, 32'(alu_control), 32'd0);
        cyc(); #1;
        chk({nm, " back to IF"}, 32'(state), 32'd1);
    endtask

    initial begin
        reset = 1'b1; inst_ack = 1'b0; inst_rdata = '0; data_ack = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset outputs", all_outs(), 32'd0);
            cyc();
        end
        reset = 1'b0; #1;
        chk("RST after release", all_outs(), 32'd0);
        cyc(); #1;
        chk("first IF state", 32'(state), 32'd1);
        chk("first IF req", 32'(inst_req), 32'd1);
        chk("first IF alu_control", 32'(alu_control), 32'h001);
        chk("first IF src", {28'd0, alu_src1_sel, alu_src2_sel}, {28'd0, 2'd2, 2'd3});
        chk("first IF no ack pc_we", 32'(pc_we), 32'd0);

        run_alu("addu", 32'h00221821, 12'h001, 2'd0, 2'd0, 1'b0);
        run_alu("sra",  32'h00021883, 12'h400, 2'd1, 2'd0, 1'b0);
        run_alu("lui",  32'h3C01ABCD, 12'h800, 2'd0, 2'd2, 1'b1);
        run_alu("andi", 32'h302100FF, 12'h010, 2'd0, 2'd2, 1'b1);
        run_alu("slti", 32'h2821FFFF, 12'h004, 2'd0, 2'd1, 1'b1);
        run_alu("sub",  32'h00221822, 12'h002, 2'd0, 2'd0, 1'b0);
        run_alu("sllv", 32'h00221804, 12'h100, 2'd0, 2'd0, 1'b0);
        run_alu("nor",  32'h00221827, 12'h020, 2'd0, 2'd0, 1'b0);
        run_alu("sltu", 32'h0022182B, 12'h008, 2'd0, 2'd0, 1'b0);

        // lw with data_ack three cycles late: IF,ID,EX,MEMx4,WB = 8 cycles
        inst_ack = 1'b1; inst_rdata = 32'h8C220004;
        cyc(); inst_ack = 1'b0;
        cyc(); #1;
        chk("lw EX", {16'd0, alu_control, alu_src1_sel, alu_src2_sel}, {16'd0, 12'h001, 2'd0, 2'd1});
        for (int i = 0; i < 4; i++) begin
            cyc();
            data_ack = (i == 3);
            #1;
            chk("lw MEM req/wr", {29'd0, state, data_req, data_wr} >> 0, {27'd0, 3'd4, 1'b1, 1'b0});
        end
        cyc(); data_ack = 1'b0; #1;
        chk("lw WB", {28'd0, state, rf_we, rf_wdst_sel, rf_wdata_sel} >> 0,
            {25'd0, 3'd5, 1'b1, 1'b1, 1'b1});
        cyc(); #1;
        chk("lw back to IF", 32'(state), 32'd1);

        // sw, data_ack in first MEM cycle, returns straight to IF
        inst_ack = 1'b1; inst_rdata = 32'hAC220004;
        cyc(); inst_ack = 1'b0;
        cyc();
        cyc(); data_ack = 1'b1; #1;
        chk("sw MEM", {29'd0, state, data_req, data_wr}, {27'd0, 3'd4, 1'b1, 1'b1});
        cyc(); data_ack = 1'b0; #1;
        chk("sw back to IF", {29'd0, state, rf_we, data_req}, {27'd0, 3'd1, 2'b00});

        // illegal opcode and illegal R-type funct
        inst_ack = 1'b1; inst_rdata = 32'hFC000000;
        cyc(); inst_ack = 1'b0; #1;
        chk("illegal op ID pulse", {29'd0, state, illegal_inst}, {28'd0, 3'd2, 1'b1});
        cyc(); #1;
        chk("illegal op next IF", {28'd0, state, illegal_inst, rf_we, data_req},
            {28'd0, 3'd1, 3'b000});
        inst_ack = 1'b1; inst_rdata = 32'h00000001;
        cyc(); inst_ack = 1'b0; #1;
        chk("illegal funct ID pulse", 32'(illegal_inst), 32'd1);
        cyc(); #1;
        chk("illegal funct next IF", 32'(state), 32'd1);

        // inst_ack stuck low: bus_err on the 8th IF cycle only
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) begin
                chk("IF wait no bus_err", 32'(bus_err), 32'd0);
                cyc();
            end else begin
                chk("IF timeout bus_err", {30'd0, bus_err, pc_we}, 32'h2);
                chk("IF timeout req", 32'(inst_req), 32'd1);
            end
        end
        cyc(); #1;
        chk("after IF timeout", {29'd0, state, bus_err}, {28'd0, 3'd1, 1'b0});

        // ack on the 8th cycle beats the timeout
        for (int i = 1; i < 8; i++) cyc();
        inst_ack = 1'b1; inst_rdata = 32'h8C220004; #1;
        chk("ack on 8th wins", {30'd0, bus_err, pc_we}, 32'h1);
        cyc(); inst_ack = 1'b0; #1;
        chk("ack on 8th -> ID", 32'(state), 32'd2);

        // lw whose data_ack never comes: bus_err on 8th MEM cycle, no WB
        cyc(); cyc(); #1;
        for (int i = 1; i < 8; i++) begin
            chk("MEM wait no bus_err", {29'd0, state, bus_err}, {28'd0, 3'd4, 1'b0});
            cyc();
        end
        chk("MEM timeout bus_err", {29'd0, state, bus_err}, {28'd0, 3'd4, 1'b1});
        cyc(); #1;
        chk("after MEM timeout", {28'd0, state, rf_we, bus_err, data_req}, {28'd0, 3'd1, 3'b000});

        // reset asserted mid-MEM aborts immediately
        inst_ack = 1'b1; inst_rdata = 32'hAC220004;
        cyc(); inst_ack = 1'b0;
        cyc(); cyc(); #1;
        chk("pre-reset MEM req", 32'(data_req), 32'd1);
        reset = 1'b1; #1;
        chk("reset mid-MEM outputs", all_outs(), 32'd0);
        cyc(); reset = 1'b0; #1;
        chk("post-reset RST", 32'(state), 32'd0);
        cyc(); #1;
        chk("post-reset IF", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
